// File: rtl/u712_bus_sizer_if.sv
// Request and target-port signal bundle for the U712 bus sizer.
// The master modport is the sizer itself; slave is the requester/target side.
interface u712_bus_sizer_if #(
    parameter int PORT_WIDTH = 2
);
    logic                  START;
    logic [1:0]            SIZ;
    logic [1:0]            A;
    logic                  PORT_ACK;
    logic                  PORT_STB;
    logic [1:0]            PORT_A;
    logic [1:0]            LINE_BEAT;
    logic [3:0]            BE_n;
    logic [PORT_WIDTH-1:0] PORT_BE_n;
    logic                  BUSY;
    logic                  DONE;
    logic                  ERR;

    modport master (
        input  START, SIZ, A, PORT_ACK,
        output PORT_STB, PORT_A, LINE_BEAT, BE_n, PORT_BE_n, BUSY, DONE, ERR
    );

    modport slave (
        output START, SIZ, A, PORT_ACK,
        input  PORT_STB, PORT_A, LINE_BEAT, BE_n, PORT_BE_n, BUSY, DONE, ERR
    );
endinterface

// File: rtl/u712_bus_sizer.sv
// U712 bus sizer: splits one 68040 SIZ/A request into handshaken beats on an 8/16/32-bit port.
// Optional per-beat acknowledge watchdog is built when U712_SIZER_TIMEOUT_EN is defined.
module u712_bus_sizer #(
    parameter int PORT_WIDTH     = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic              CLK40,
    input logic              RESET,
    u712_bus_sizer_if.master bus
);
    generate
        if (PORT_WIDTH != 1 && PORT_WIDTH != 2 && PORT_WIDTH != 4) begin : g_bad_width
            $error("u712_bus_sizer: PORT_WIDTH must be 1, 2 or 4");
        end
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
            $error("u712_bus_sizer: TIMEOUT_CYCLES must be at least 1");
        end
    endgenerate

    localparam logic [2:0] PW = 3'(PORT_WIDTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STROBE  = 2'd1,
        RECOVER = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [4:0]            rem_q, rem_d;
    logic [1:0]            addr_q, addr_d;
    logic [1:0]            lbeat_q, lbeat_d;
    logic                  line_q, line_d;
    logic                  done_q, done_d;
    logic [2:0]            room;
    logic [2:0]            k;
    logic [2:0]            addr_sum;
    logic [3:0]            be_n;
    logic [PORT_WIDTH-1:0] pbe_n;
    logic                  timeout_hit;

`ifdef U712_SIZER_TIMEOUT_EN
    localparam int WD_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_q;
    logic            err_q;

    assign timeout_hit = (wd_q == WD_LAST);

    // Watchdog restarts on every entry to STROBE, so each beat gets a fresh budget.
    always_ff @(posedge CLK40) begin
        if (RESET || state_q != STROBE || state_d != STROBE) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_q + 1'b1;
        end
    end

    always_ff @(posedge CLK40) begin
        if (RESET) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (state_q == STROBE) && !bus.PORT_ACK && timeout_hit;
        end
    end

    assign bus.ERR = err_q;
`else
    assign timeout_hit = 1'b0;
    assign bus.ERR     = 1'b0;
`endif

    // Beat size is capped by what is left, the port width and the longword boundary.
    always_comb begin
        room = 3'd4 - {1'b0, addr_q};
        k    = PW;
        if (room < k) k = room;
        if (rem_q < {2'b00, k}) k = rem_q[2:0];
        addr_sum = {1'b0, addr_q} + k;
    end

    always_comb begin
        be_n  = 4'hF;
        pbe_n = '1;
        if (state_q == STROBE) begin
            for (int j = 0; j < 4; j++) begin
                if (3'(j) < k) begin
                    be_n  = be_n & ~(4'b0001 << (3 - (int'(addr_q) + j)));
                    pbe_n = pbe_n & ~(PORT_WIDTH'(1) <<
                            (PORT_WIDTH - 1 - ((int'(addr_q) + j) % PORT_WIDTH)));
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        addr_d  = addr_q;
        lbeat_d = lbeat_q;
        line_d  = line_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.START) begin
                    state_d = STROBE;
                    lbeat_d = 2'd0;
                    line_d  = (bus.SIZ == 2'b11);
                    unique case (bus.SIZ)
                        2'b01:   begin rem_d = 5'd1;  addr_d = bus.A;              end
                        2'b10:   begin rem_d = 5'd2;  addr_d = {bus.A[1], 1'b0};   end
                        2'b11:   begin rem_d = 5'd16; addr_d = 2'b00;              end
                        default: begin rem_d = 5'd4;  addr_d = 2'b00;              end
                    endcase
                end
            end
            STROBE: begin
                if (bus.PORT_ACK) begin
                    rem_d  = rem_q - {2'b00, k};
                    addr_d = addr_sum[1:0];
                    if (line_q && addr_sum[2]) lbeat_d = lbeat_q + 2'd1;
                    if (rem_d == 5'd0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RECOVER;
                    end
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            RECOVER: state_d = STROBE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK40) begin
        if (RESET) begin
            state_q <= IDLE;
            addr_q  <= 2'b00;
            lbeat_q <= 2'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            lbeat_q <= lbeat_d;
            done_q  <= done_d;
        end
    end

    // Byte count and line flag are only meaningful once a request is latched.
    always_ff @(posedge CLK40) begin
        rem_q  <= rem_d;
        line_q <= line_d;
    end

    assign bus.PORT_STB  = (state_q == STROBE);
    assign bus.BUSY      = (state_q != IDLE);
    assign bus.DONE      = done_q;
    assign bus.PORT_A    = addr_q;
    assign bus.LINE_BEAT = lbeat_q;
    assign bus.BE_n      = be_n;
    assign bus.PORT_BE_n = pbe_n;
endmodule

// File: doc/u712_bus_sizer.md
Name: u712_bus_sizer

Overview:
- Successor to the U712 combinational byte-enable decode, generalised to a parametrised port width.
- Takes one 68040-style transfer request (SIZ, A[1:0]) on the 32-bit local bus and sequences it into one or more beats on a narrower or equal-width target port (8/16/32-bit).
- Each beat drives both host-lane and port-lane byte enables, and beats are handshaken individually with the target.
- Sits between the U712 CPU/DMA cycle logic and the chipset/PCI-side data path.

Parameters:
PORT_WIDTH, 2, target port width in bytes; legal values 1, 2, 4; any other value is an elaboration error.
TIMEOUT_CYCLES, 255, per-beat acknowledge watchdog limit in clocks; used only with the optional feature.

Ports:
CLK40  input  1  block clock; all logic is on the rising edge.
RESET  input  1  synchronous, active-high reset.
START  input  1  request strobe; sampled only in IDLE.
SIZ  input  2  transfer size: 00 longword, 01 byte, 10 word, 11 line (16 bytes).
A  input  2  byte address within the longword.
PORT_ACK  input  1  target acknowledge for the current beat; valid only while PORT_STB=1.
PORT_STB  output  1  beat strobe to the target.
PORT_A  output  2  byte address of the current beat.
LINE_BEAT  output  2  longword index within a line transfer; 0 for all other sizes.
BE_n  output  4  active-low host-lane enables; [3]=UU, [2]=UM, [1]=LM, [0]=LL.
PORT_BE_n  output  PORT_WIDTH  active-low port-lane enables; the MSB is the even/upper byte.
BUSY  output  1  transfer in progress.
DONE  output  1  one-clock pulse when the final beat is acknowledged.
ERR  output  1  one-clock pulse on watchdog abort.

Behaviour:
Reset values:
- PORT_STB=0, BUSY=0, DONE=0, ERR=0, PORT_A=0, LINE_BEAT=0, BE_n=4'hF, PORT_BE_n=all ones.
- RESET asserted mid-transfer forces these values at the next edge and returns the FSM to IDLE. No DONE is issued.

States: IDLE, STROBE, RECOVER.

IDLE:
- On START=1, latch the request and enter STROBE at the next edge. BUSY and PORT_STB both go high at that edge, so latency from START sampled to first strobe is 1 clock.
- Alignment rules:
  - Longword and line: A is ignored, start address is 00.
  - Word: A[0] is ignored, start address is {A[1],0}.
  - Byte: A is used as given.
- Remaining byte count is loaded as 1, 2, 4 or 16 (5-bit counter).

Beat formation:
- Beat byte count k = min(remaining, PORT_WIDTH, 4 - PORT_A).
- BE_n clears bits [3-PORT_A] down to [3-(PORT_A+k-1)].
- PORT_BE_n clears bits [PORT_WIDTH-1-(PORT_A mod PORT_WIDTH)] downward for k bits.
- BE_n and PORT_BE_n are held stable for the whole time PORT_STB=1, and are all ones otherwise.

STROBE:
- PORT_STB=1 is held until PORT_ACK=1 is sampled.
- On ACK, remaining -= k and PORT_A += k (mod 4). On the 2-bit wrap, LINE_BEAT increments.
- If remaining becomes 0: at the next edge DONE=1 for one clock, BUSY=0, PORT_STB=0, state returns to IDLE.
- Otherwise: enter RECOVER.

RECOVER:
- PORT_STB=0 for exactly one clock, then return to STROBE with the next beat.

Ignored inputs and other rules:
- START while BUSY=1 is ignored and is not queued.
- PORT_ACK outside STROBE is ignored.
- START on the same edge that DONE is issued is ignored; the block must be in IDLE before a new request is taken.
- Line transfers always produce 16/PORT_WIDTH beats. PORT_A wraps 11->00 within each longword.

Optional Feature:
Macro U712_SIZER_TIMEOUT_EN.
- Defined:
  - An 8-bit-minimum watchdog counts clocks in STROBE and clears on each ACK.
  - On reaching TIMEOUT_CYCLES, the next edge pulses ERR for one clock, drops PORT_STB and BUSY, and returns to IDLE. No DONE is issued.
- Not defined:
  - No counter is built, ERR is tied to 0, and STROBE waits indefinitely.

Test Plan:
1. PORT_WIDTH=2: longword (SIZ=00, A=11), ACK on the first strobe clock of each beat.
   Required: beat 1 PORT_A=00, BE_n=0011, PORT_BE_n=00; 1-clock STB gap; beat 2 PORT_A=10, BE_n=1100, PORT_BE_n=00; DONE 1 clock after the second ACK.
2. PORT_WIDTH=2: byte (SIZ=01, A=01).
   Required: single beat with BE_n=1011, PORT_BE_n=10, PORT_STB high 1 clock after START; DONE after ACK.
3. PORT_WIDTH=1: word (SIZ=10, A=11).
   Required: aligned to 10; beats BE_n=1101 then BE_n=1110; PORT_BE_n=0 on both.
4. PORT_WIDTH=4: line (SIZ=11).
   Required: 4 beats, all BE_n=0000; LINE_BEAT steps 0,1,2,3; START pulsed during beat 2 is ignored.
5. PORT_WIDTH=2: RESET asserted while STB is waiting on beat 1 of a longword.
   Required: next edge gives STB=0, BUSY=0, BE_n=F, no DONE; a fresh byte request afterwards completes normally.
6. With U712_SIZER_TIMEOUT_EN and TIMEOUT_CYCLES=8: no ACK.
   Required: ERR pulses 1 clock after 8 strobe clocks, BUSY drops, DONE never asserts. Without the macro, STB remains high for 100 clocks and ERR=0.
